// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, byte-serial refill over the shared memory
// port, and a direct-mapped instruction cache feeding the IF/ID register.
module if_fetch #(
    parameter logic [31:0] RESET_PC          = 32'h0,
    parameter int unsigned ICACHE_INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    localparam int unsigned ENTRIES = 1 << ICACHE_INDEX_BITS;
    localparam int unsigned TAG_W   = 32 - ICACHE_INDEX_BITS - 2;

    typedef enum logic [1:0] {
        S_LOOKUP,
        S_FETCH,
        S_VALID,
        S_DRAIN
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [31:0]                    r_pc;
    logic [31:0]                    r_inst;
    logic                           r_valid;
    logic [2:0]                     r_issue_cnt;
    logic [1:0]                     r_recv_cnt;
    logic                           r_rsp_valid;
    logic [23:0]                    r_word;

    logic [ENTRIES-1:0]             r_cache_vld;
    logic [TAG_W-1:0]               r_cache_tag  [ENTRIES];
    logic [31:0]                    r_cache_data [ENTRIES];

    logic [31:0]                    w_pc_plus4;
    logic [31:0]                    w_lookup_pc;
    logic [ICACHE_INDEX_BITS-1:0]   w_lookup_idx;
    logic [TAG_W-1:0]               w_lookup_tag;
    logic                           w_hit;
    logic [31:0]                    w_hit_data;
    logic [ICACHE_INDEX_BITS-1:0]   w_fill_idx;
    logic [TAG_W-1:0]               w_fill_tag;
    logic                           w_req;
    logic                           w_capture;
    logic                           w_fill_done;
    logic [31:0]                    w_fill_word;
    logic                           w_cache_we;
    logic                           w_unused;

    assign w_pc_plus4   = r_pc + 32'd4;
    // In VALID the lookup targets the next sequential PC so hits stream one per cycle.
    assign w_lookup_pc  = (r_state == S_VALID) ? w_pc_plus4 : r_pc;
    assign w_lookup_idx = w_lookup_pc[ICACHE_INDEX_BITS+1:2];
    assign w_lookup_tag = w_lookup_pc[31:ICACHE_INDEX_BITS+2];
    assign w_hit        = r_cache_vld[w_lookup_idx] && (r_cache_tag[w_lookup_idx] == w_lookup_tag);
    assign w_hit_data   = r_cache_data[w_lookup_idx];

    assign w_fill_idx   = r_pc[ICACHE_INDEX_BITS+1:2];
    assign w_fill_tag   = r_pc[31:ICACHE_INDEX_BITS+2];
    assign w_req        = (r_state == S_FETCH) && !r_issue_cnt[2];
    assign w_capture    = (r_state == S_FETCH) && r_rsp_valid;
    assign w_fill_done  = w_capture && (r_recv_cnt == 2'd3);
    assign w_fill_word  = {mem_data_i, r_word};
    assign w_cache_we   = w_fill_done && !branch_taken_i;

    assign mem_req_o    = w_req;
    assign mem_addr_o   = w_req ? (r_pc + {29'b0, r_issue_cnt}) : 32'b0;
    assign pc_o         = r_pc;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;

    assign w_unused     = ^{branch_target_i[1:0], w_lookup_pc[1:0]};

    always_comb begin
        w_state_next = r_state;
        if (branch_taken_i) begin
            w_state_next = S_DRAIN;
        end else begin
            case (r_state)
                S_LOOKUP: w_state_next = w_hit ? S_VALID : S_FETCH;
                S_FETCH:  if (w_fill_done) w_state_next = S_VALID;
                S_VALID:  if (!stall_i && !w_hit) w_state_next = S_FETCH;
                S_DRAIN:  w_state_next = S_LOOKUP;
                default:  w_state_next = S_LOOKUP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOOKUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc        <= RESET_PC;
            r_inst      <= 32'b0;
            r_valid     <= 1'b0;
            r_issue_cnt <= 3'd0;
            r_recv_cnt  <= 2'd0;
            r_rsp_valid <= 1'b0;
            r_word      <= 24'b0;
        end else begin
            r_rsp_valid <= w_req && mem_grant_i;
            if (branch_taken_i) begin
                r_pc        <= {branch_target_i[31:2], 2'b00};
                r_valid     <= 1'b0;
                r_issue_cnt <= 3'd0;
                r_recv_cnt  <= 2'd0;
            end else begin
                case (r_state)
                    S_LOOKUP: begin
                        if (w_hit) begin
                            r_inst  <= w_hit_data;
                            r_valid <= 1'b1;
                        end else begin
                            r_issue_cnt <= 3'd0;
                            r_recv_cnt  <= 2'd0;
                        end
                    end
                    S_FETCH: begin
                        if (w_req && mem_grant_i) begin
                            r_issue_cnt <= r_issue_cnt + 3'd1;
                        end
                        if (w_capture) begin
                            case (r_recv_cnt)
                                2'd0:    r_word[7:0]   <= mem_data_i;
                                2'd1:    r_word[15:8]  <= mem_data_i;
                                2'd2:    r_word[23:16] <= mem_data_i;
                                default: ;
                            endcase
                            r_recv_cnt <= r_recv_cnt + 2'd1;
                        end
                        if (w_fill_done) begin
                            r_inst  <= w_fill_word;
                            r_valid <= 1'b1;
                        end
                    end
                    S_VALID: begin
                        if (!stall_i) begin
                            r_pc <= w_pc_plus4;
                            if (w_hit) begin
                                r_inst <= w_hit_data;
                            end else begin
                                r_valid     <= 1'b0;
                                r_issue_cnt <= 3'd0;
                                r_recv_cnt  <= 2'd0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Only valid bits need clearing on reset; tag/data are qualified by them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cache_vld <= '0;
        end else if (w_cache_we) begin
            r_cache_vld[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_cache_we) begin
            r_cache_tag[w_fill_idx]  <= w_fill_tag;
            r_cache_data[w_fill_idx] <= w_fill_word;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed cycle-exact scenarios followed by randomized traffic
// checked against a program-order PC model and a byte-addressed memory image.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = 32'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_grant_i = 1'b0;
    logic [7:0]  mem_data_i = 8'b0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    logic [7:0]  mem [0:511];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] exp_pc = 32'b0;
    bit          model_on = 1'b0;
    int          idle = 0;
    int          max_idle = 0;
    int          req_seen = 0;

    if_fetch #(.RESET_PC(32'h0), .ICACHE_INDEX_BITS(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_grant_i     (mem_grant_i),
        .mem_data_i      (mem_data_i),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        w = 32'b0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] x;
            x = a + 32'(i);
            w[i*8 +: 8] = mem[x[8:0]];
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_model(input bit held);
        chk("pc_model", pc_o, exp_pc);
        if (inst_valid_o) chk("inst_vs_mem", inst_o, word_at(pc_o));
        if (!mem_req_o) chk("addr_idle_zero", mem_addr_o, 32'h0);
        else            chk("addr_window", 32'((mem_addr_o - pc_o) < 32'd4), 32'd1);
        if (held) chk("stall_hold_valid", 32'(inst_valid_o), 32'd1);
    endtask

    // One clock: memory answers a grant with the addressed byte on the next cycle.
    task automatic tick();
        logic        g;
        logic        cons;
        logic        br;
        logic        held;
        logic [31:0] a;
        logic [31:0] tgt;
        g    = mem_grant_i && mem_req_o;
        a    = mem_addr_o;
        cons = inst_valid_o && !stall_i;
        br   = branch_taken_i;
        tgt  = branch_target_i;
        held = inst_valid_o && stall_i && !branch_taken_i;
        @(posedge clk);
        #1;
        cyc++;
        mem_data_i = g ? mem[a[8:0]] : 8'($urandom);
        if (br)        exp_pc = {tgt[31:2], 2'b00};
        else if (cons) exp_pc = exp_pc + 32'd4;
        if (mem_req_o) req_seen++;
        if (inst_valid_o) idle = 0; else idle++;
        if (idle > max_idle) max_idle = idle;
        if (model_on) check_model(held);
    endtask

    task automatic do_reset();
        model_on        = 1'b0;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'b0;
        mem_grant_i     = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0);
        tick();
        tick();
        rst      = 1'b1;
        exp_pc   = 32'h0;
        cyc      = 0;
        idle     = 0;
        model_on = 1'b1;
    endtask

    task automatic wait_valid_pc(input logic [31:0] pc, input string tag);
        int n;
        n = 0;
        while (!(inst_valid_o && pc_o == pc) && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 100), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h50; mem[3] = 8'h00;
        mem[9'h104] = mem[2] ^ 8'h5A;
        #2;

        // Contiguous-grant fill, then a 5-cycle stall hold.
        do_reset();
        mem_grant_i = 1'b1;
        stall_i = 1'b1;
        chk("c0_req", 32'(mem_req_o), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("fill_req", 32'(mem_req_o), 32'd1);
            chk("fill_addr", mem_addr_o, 32'(c - 1));
        end
        tick();
        chk("c5_req", 32'(mem_req_o), 32'd0);
        chk("c5_valid", 32'(inst_valid_o), 32'd0);
        tick();
        chk("c6_valid", 32'(inst_valid_o), 32'd1);
        chk("c6_inst", inst_o, 32'h00500513);
        chk("c6_pc", pc_o, 32'h0);
        repeat (5) begin
            tick();
            chk("stall_pc", pc_o, 32'h0);
            chk("stall_inst", inst_o, 32'h00500513);
            chk("stall_valid", 32'(inst_valid_o), 32'd1);
        end
        stall_i = 1'b0;
        tick();
        chk("unstall_pc", pc_o, 32'h4);

        // Fill with grants withheld in cycles 2 and 3.
        do_reset();
        mem_grant_i = 1'b1;
        stall_i = 1'b1;
        tick(); chk("gap_c1_addr", mem_addr_o, 32'h0);
        tick(); chk("gap_c2_addr", mem_addr_o, 32'h1); mem_grant_i = 1'b0;
        tick(); chk("gap_c3_addr", mem_addr_o, 32'h1);
        tick(); chk("gap_c4_addr", mem_addr_o, 32'h1); mem_grant_i = 1'b1;
        tick(); chk("gap_c5_addr", mem_addr_o, 32'h2);
        tick(); chk("gap_c6_addr", mem_addr_o, 32'h3);
        tick(); chk("gap_c7_valid", 32'(inst_valid_o), 32'd0);
        tick(); chk("gap_c8_valid", 32'(inst_valid_o), 32'd1);
        chk("gap_c8_inst", inst_o, 32'h00500513);

        // Four-instruction loop: second pass must run from cache at one per cycle.
        do_reset();
        mem_grant_i = 1'b1;
        wait_valid_pc(32'hC, "loop_pass1_timeout");
        branch_taken_i = 1'b1;
        branch_target_i = 32'h0;
        req_seen = 0;
        tick();
        branch_taken_i = 1'b0;
        wait_valid_pc(32'h0, "loop_pass2_timeout");
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("loop_pc", pc_o, 32'(4 * k));
            chk("loop_valid", 32'(inst_valid_o), 32'd1);
        end
        chk("loop_no_req", 32'(req_seen), 32'd0);

        // Redirect after byte 1 is granted; stale byte from the redirect cycle dropped.
        do_reset();
        mem_grant_i = 1'b1;
        tick();
        tick();
        tick();
        branch_taken_i = 1'b1;
        branch_target_i = 32'h107;
        tick();
        branch_taken_i = 1'b0;
        chk("redir_valid", 32'(inst_valid_o), 32'd0);
        chk("redir_drain_req", 32'(mem_req_o), 32'd0);
        chk("redir_pc", pc_o, 32'h104);
        tick(); chk("redir_lookup_req", 32'(mem_req_o), 32'd0);
        tick(); chk("redir_addr", mem_addr_o, 32'h104);
        wait_valid_pc(32'h104, "redir_fill_timeout");
        chk("redir_inst", inst_o, word_at(32'h104));
        stall_i = 1'b1;
        branch_taken_i = 1'b1;
        branch_target_i = 32'h0;
        tick();
        branch_taken_i = 1'b0;
        tick();
        tick();
        chk("aborted_entry_miss_req", 32'(mem_req_o), 32'd1);
        chk("aborted_entry_miss_addr", mem_addr_o, 32'h0);

        // Asynchronous reset mid-fetch, with PC 0 cached beforehand.
        wait_valid_pc(32'h0, "pre_rst_fill_timeout");
        stall_i = 1'b0;
        branch_taken_i = 1'b1;
        branch_target_i = 32'h200;
        tick();
        branch_taken_i = 1'b0;
        tick();
        tick();
        tick();
        #3;
        model_on = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_rst_pc", pc_o, 32'h0);
        chk("async_rst_inst", inst_o, 32'h0);
        chk("async_rst_valid", 32'(inst_valid_o), 32'd0);
        chk("async_rst_req", 32'(mem_req_o), 32'd0);
        chk("async_rst_addr", mem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_pc = 32'h0;
        model_on = 1'b1;
        tick();
        chk("post_rst_miss_req", 32'(mem_req_o), 32'd1);
        chk("post_rst_miss_addr", mem_addr_o, 32'h0);

        // PC wrap from the top of the address space.
        stall_i = 1'b1;
        branch_taken_i = 1'b1;
        branch_target_i = 32'hFFFF_FFFC;
        tick();
        branch_taken_i = 1'b0;
        wait_valid_pc(32'hFFFF_FFFC, "wrap_fill_timeout");
        stall_i = 1'b0;
        tick();
        chk("wrap_pc", pc_o, 32'h0);

        // Randomized traffic; cache aliasing arises from targets across 0x000-0x1FF.
        max_idle = 0;
        idle = 0;
        for (int n = 0; n < 3000; n++) begin
            mem_grant_i     = ($urandom_range(0, 9) < 6);
            stall_i         = ($urandom_range(0, 9) < 3);
            branch_taken_i  = ($urandom_range(0, 99) < 4);
            branch_target_i = 32'($urandom_range(0, 511));
            tick();
        end
        branch_taken_i = 1'b0;
        chk("liveness_max_idle", 32'(max_idle < 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
